// File: rtl/pipeline_ctrl_pkg.sv
// Shared encodings, defaults and control-word helpers for the pipeline control unit.
package pipeline_ctrl_pkg;

    localparam int unsigned MEM_TIMEOUT_DEF = 255;
    localparam int unsigned STALL_CNT_W_DEF = 16;
    localparam int unsigned WAIT_CNT_W      = 8;

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_MEM_WAIT = 2'b01,
        ST_FAULT    = 2'b10,
        ST_ILLEGAL  = 2'b11
    } ctrl_state_e;

    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic ex_mem_write;
        logic if_id_flush;
        logic id_ex_flush;
        logic mem_wb_bubble;
        logic dmem_start;
    } ctrl_out_t;

    // Free-running pipeline: every stage advances, nothing squashed.
    function automatic ctrl_out_t ctrl_run();
        ctrl_out_t c;
        c              = '0;
        c.pc_write     = 1'b1;
        c.if_id_write  = 1'b1;
        c.ex_mem_write = 1'b1;
        return c;
    endfunction

    // Memory stall: hold PC through EX/MEM, drain a bubble into WB.
    function automatic ctrl_out_t ctrl_freeze(input logic start);
        ctrl_out_t c;
        c               = '0;
        c.mem_wb_bubble = 1'b1;
        c.dmem_start    = start;
        return c;
    endfunction

    function automatic ctrl_out_t ctrl_in_reset();
        ctrl_out_t c;
        c               = '0;
        c.if_id_flush   = 1'b1;
        c.id_ex_flush   = 1'b1;
        c.mem_wb_bubble = 1'b1;
        return c;
    endfunction

endpackage

// File: rtl/pipeline_control_unit_sat_counter.sv
// Up-counter with synchronous clear and saturation at all-ones.
module sat_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [WIDTH-1:0] cnt_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // Clear wins over enable; hold once all-ones is reached.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipeline_control_unit.sv
// Hazard / memory-stall controller for a 5-stage pipeline: zero-latency
// decode of write enables and flushes, plus a wait/timeout FSM for data memory.
module pipeline_control_unit
    import pipeline_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEF,
    parameter int unsigned STALL_CNT_W = STALL_CNT_W_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load_use_hazard,
    input  logic                   branch_taken,
    input  logic                   dmem_req,
    input  logic                   dmem_ready,
    input  logic                   imem_ready,
    output logic                   PC_Write,
    output logic                   IF_ID_Write,
    output logic                   EX_MEM_Write,
    output logic                   IF_ID_Flush,
    output logic                   ID_EX_Flush,
    output logic                   MEM_WB_Bubble,
    output logic                   dmem_start,
    output logic                   mem_timeout,
    output logic [1:0]             ctrl_state,
    output logic [STALL_CNT_W-1:0] stall_cycles
);

    localparam logic [WAIT_CNT_W-1:0] WAIT_LAST = WAIT_CNT_W'(MEM_TIMEOUT - 1);

    ctrl_state_e           state_q;
    ctrl_state_e           state_d;
    ctrl_out_t             ctrl_c;
    logic                  mem_stall_c;
    logic                  start_c;
    logic                  fault_entry_c;
    logic                  mem_timeout_q;
    logic                  wait_clr_c;
    logic                  wait_en_c;
    logic                  stall_en_c;
    logic [WAIT_CNT_W-1:0] wait_cnt;

    // Next state plus same-cycle control decode; memory stall outranks everything.
    always_comb begin
        state_d       = state_q;
        ctrl_c        = ctrl_run();
        mem_stall_c   = 1'b0;
        start_c       = 1'b0;
        fault_entry_c = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (dmem_req) begin
                    start_c = 1'b1;
                    if (!dmem_ready) begin
                        mem_stall_c = 1'b1;
                        state_d     = ST_MEM_WAIT;
                    end
                end
            end
            ST_MEM_WAIT: begin
                if (dmem_ready) begin
                    state_d = ST_RUN;
                end else begin
                    mem_stall_c = 1'b1;
                    if (wait_cnt == WAIT_LAST) begin
                        state_d       = ST_FAULT;
                        fault_entry_c = 1'b1;
                    end
                end
            end
            ST_FAULT: begin
                mem_stall_c = 1'b1;
            end
            default: begin
                mem_stall_c = 1'b1;
                state_d     = ST_RUN;
            end
        endcase

        // EX is frozen during a memory stall, so a branch re-presents later.
        if (mem_stall_c) begin
            ctrl_c = ctrl_freeze(start_c);
        end else if (branch_taken) begin
            ctrl_c.if_id_flush = 1'b1;
            ctrl_c.id_ex_flush = 1'b1;
        end else if (load_use_hazard) begin
            ctrl_c.pc_write    = 1'b0;
            ctrl_c.if_id_write = 1'b0;
            ctrl_c.id_ex_flush = 1'b1;
        end else if (!imem_ready) begin
            ctrl_c.pc_write    = 1'b0;
            ctrl_c.if_id_flush = 1'b1;
        end
        ctrl_c.dmem_start = start_c;

        if (!reset) begin
            ctrl_c = ctrl_in_reset();
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_RUN;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (fault_entry_c) begin
                mem_timeout_q <= 1'b1;
            end
        end
    end

    assign wait_clr_c = (state_q != ST_MEM_WAIT);
    assign wait_en_c  = (state_q == ST_MEM_WAIT) && !dmem_ready;
    assign stall_en_c = !ctrl_c.pc_write && (state_q != ST_FAULT);

    sat_counter #(
        .WIDTH (WAIT_CNT_W)
    ) u_wait_cnt (
        .clk   (clk),
        .rst_n (reset),
        .clr_i (wait_clr_c),
        .en_i  (wait_en_c),
        .cnt_o (wait_cnt)
    );

    sat_counter #(
        .WIDTH (STALL_CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst_n (reset),
        .clr_i (1'b0),
        .en_i  (stall_en_c),
        .cnt_o (stall_cycles)
    );

    assign PC_Write      = ctrl_c.pc_write;
    assign IF_ID_Write   = ctrl_c.if_id_write;
    assign EX_MEM_Write  = ctrl_c.ex_mem_write;
    assign IF_ID_Flush   = ctrl_c.if_id_flush;
    assign ID_EX_Flush   = ctrl_c.id_ex_flush;
    assign MEM_WB_Bubble = ctrl_c.mem_wb_bubble;
    assign dmem_start    = ctrl_c.dmem_start;
    assign mem_timeout   = mem_timeout_q;
    assign ctrl_state    = state_q;

endmodule

// File: tb/tb_pipeline_control_unit.sv
// Randomized bench for pipeline_control_unit against a cycle-level behavioural model.
module tb_pipeline_control_unit;

    localparam int unsigned TO   = 4;
    localparam int unsigned SW   = 4;
    localparam int          SMAX = (1 << SW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          load_use_hazard, branch_taken, dmem_req, dmem_ready, imem_ready;
    logic          PC_Write, IF_ID_Write, EX_MEM_Write;
    logic          IF_ID_Flush, ID_EX_Flush, MEM_WB_Bubble;
    logic          dmem_start, mem_timeout;
    logic [1:0]    ctrl_state;
    logic [SW-1:0] stall_cycles;

    pipeline_control_unit #(
        .MEM_TIMEOUT (TO),
        .STALL_CNT_W (SW)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .load_use_hazard (load_use_hazard),
        .branch_taken    (branch_taken),
        .dmem_req        (dmem_req),
        .dmem_ready      (dmem_ready),
        .imem_ready      (imem_ready),
        .PC_Write        (PC_Write),
        .IF_ID_Write     (IF_ID_Write),
        .EX_MEM_Write    (EX_MEM_Write),
        .IF_ID_Flush     (IF_ID_Flush),
        .ID_EX_Flush     (ID_EX_Flush),
        .MEM_WB_Bubble   (MEM_WB_Bubble),
        .dmem_start      (dmem_start),
        .mem_timeout     (mem_timeout),
        .ctrl_state      (ctrl_state),
        .stall_cycles    (stall_cycles)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Model: mode 0 = running, 1 = waiting on data memory, 2 = faulted.
    int m_mode   = 0;
    int m_waited = 0;
    int m_stalls = 0;
    bit m_to     = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [6:0] ctrl_vec();
        return {PC_Write, IF_ID_Write, EX_MEM_Write, IF_ID_Flush, ID_EX_Flush, MEM_WB_Bubble, dmem_start};
    endfunction

    // Expected {pc,ifw,exw,iff,idf,bub,start} from the priority rules.
    function automatic logic [6:0] exp_ctrl();
        bit frozen;
        bit start;
        start  = (m_mode == 0) && dmem_req;
        frozen = (m_mode == 2) || ((m_mode == 1) && !dmem_ready) || (start && !dmem_ready);
        if (frozen)           return {6'b000001, start};
        if (branch_taken)     return {6'b111110, start};
        if (load_use_hazard)  return {6'b001010, start};
        if (!imem_ready)      return {6'b011100, start};
        return {6'b111000, start};
    endfunction

    task automatic set_idle();
        dmem_req = 1'b0; dmem_ready = 1'b1; branch_taken = 1'b0;
        load_use_hazard = 1'b0; imem_ready = 1'b1;
    endtask

    task automatic step(input bit req, input bit rdy, input bit br, input bit lu, input bit im);
        logic [6:0] e;
        @(negedge clk);
        dmem_req = req; dmem_ready = rdy; branch_taken = br;
        load_use_hazard = lu; imem_ready = im;
        #2;
        e = exp_ctrl();
        check_eq("ctrl", 32'(ctrl_vec()), 32'(e));
        check_eq("state", 32'(ctrl_state), 32'(m_mode));
        check_eq("timeout", 32'(mem_timeout), 32'(m_to));
        check_eq("stalls", 32'(stall_cycles), 32'(m_stalls));
        if (!e[6] && (m_mode != 2)) m_stalls = (m_stalls == SMAX) ? SMAX : m_stalls + 1;
        case (m_mode)
            0: if (req && !rdy) begin m_mode = 1; m_waited = 0; end
            1: begin
                if (rdy) m_mode = 0;
                else begin
                    m_waited++;
                    if (m_waited == TO) begin m_mode = 2; m_to = 1'b1; end
                end
            end
            default: ;
        endcase
    endtask

    // Assert reset between edges, check the immediate effect, then release.
    task automatic do_reset();
        @(negedge clk);
        #1 reset = 1'b0;
        #1;
        check_eq("rst_ctrl", 32'(ctrl_vec()), 32'(7'b0001110));
        check_eq("rst_state", 32'(ctrl_state), 32'd0);
        check_eq("rst_stalls", 32'(stall_cycles), 32'd0);
        check_eq("rst_timeout", 32'(mem_timeout), 32'd0);
        set_idle();
        m_mode = 0; m_waited = 0; m_stalls = 0; m_to = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        int dwell;
        reset = 1'b0;
        set_idle();
        do_reset();

        // Zero-wait access
        step(1, 1, 0, 0, 1);
        step(0, 1, 0, 0, 1);
        check_eq("zw_state", 32'(ctrl_state), 32'd0);
        check_eq("zw_stalls", 32'(stall_cycles), 32'd0);

        // Three-cycle wait
        do_reset();
        step(1, 0, 0, 0, 1);
        step(1, 0, 1, 0, 1);
        step(1, 0, 0, 1, 1);
        step(1, 1, 0, 0, 1);
        step(0, 1, 0, 0, 1);
        check_eq("wait3_stalls", 32'(stall_cycles), 32'd3);

        // Branch overrides load-use
        step(0, 1, 1, 1, 1);
        step(0, 1, 1, 1, 0);

        // Timeout into fault, held until reset
        do_reset();
        step(1, 0, 0, 0, 1);
        for (int i = 0; i < TO; i++) step(1, 0, 0, 0, 1);
        step(1, 1, 1, 0, 1);
        check_eq("fault_state", 32'(ctrl_state), 32'd2);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 1);
        check_eq("fault_sticky", 32'(mem_timeout), 32'd1);

        // Reset in the middle of a wait
        do_reset();
        step(1, 0, 0, 0, 1);
        step(1, 0, 0, 0, 1);
        dmem_req = 1'b1; dmem_ready = 1'b0;
        do_reset();
        step(0, 1, 0, 0, 1);
        step(1, 1, 0, 0, 1);

        // Stall counter saturation
        for (int i = 0; i < SMAX + 2; i++) step(0, 1, 0, 1, 1);
        check_eq("sat_stalls", 32'(stall_cycles), 32'(SMAX));

        // Randomized traffic with occasional resets
        do_reset();
        dwell = 0;
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) == 0, $urandom_range(0, 4) < 3,
                 $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0,
                 $urandom_range(0, 4) != 0);
            dwell = (m_mode == 2) ? dwell + 1 : 0;
            if (dwell > 6 || $urandom_range(0, 59) == 0) begin
                do_reset();
                dwell = 0;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
